// File: rtl/interval_tick_sequencer.sv
// rtl/interval_tick_sequencer.sv - interval-timer tick to per-servo ICS command frame sequencer
//
// Ports:
//   ap_clk, ap_rst       clock, synchronous active-high reset
//   tick_i               interval-timer interrupt level (rising edge starts a frame)
//   enable_i             gates frame starts and overrun counting
//   num_servo_i[4:0]     servos per frame, latched at frame start (0 = ignore ticks)
//   cmd_valid_o/ready_i  command handshake to the ICS transaction engine
//   cmd_id_o[4:0]        servo ID of the pending command
//   cmd_last_o           pending command is the final one of the frame
//   done_i               one-cycle transaction-complete pulse
//   busy_o               frame in progress
//   frame_done_o         one-cycle pulse after the last transaction of a frame
//   frame_cnt_o[15:0]    completed frames (wrapping)
//   overrun_cnt_o[15:0]  ticks dropped while busy (saturating)
//   timeout_cnt_o[15:0]  abandoned transactions (saturating)
module interval_tick_sequencer #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        tick_i,
  input  logic        enable_i,
  input  logic [4:0]  num_servo_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [4:0]  cmd_id_o,
  output logic        cmd_last_o,
  input  logic        done_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] overrun_cnt_o,
  output logic [15:0] timeout_cnt_o
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_e;

  state_e        state_q;
  logic          tick_q;
  logic [4:0]    n_q;
  logic [4:0]    id_q;
  logic [TW-1:0] to_cnt_q;
  logic          cmd_valid_q;
  logic          cmd_last_q;
  logic          busy_q;
  logic          frame_done_q;
  logic [15:0]   frame_cnt_q;
  logic [15:0]   overrun_cnt_q;
  logic [15:0]   timeout_cnt_q;

  logic       tick_edge;
  logic [4:0] id_d;
  logic [4:0] n_last;
  logic       to_expired;

  assign tick_edge  = tick_i & ~tick_q;
  assign id_d       = id_q + 5'd1;
  assign n_last     = n_q - 5'd1;
  assign to_expired = (to_cnt_q == TO_LAST);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      tick_q        <= 1'b0;
      n_q           <= '0;
      id_q          <= '0;
      to_cnt_q      <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      tick_q       <= tick_i;
      frame_done_q <= 1'b0;

      // Any non-idle state drops the tick, including the frame-end cycle.
      if (tick_edge && enable_i && (state_q != S_IDLE) && (overrun_cnt_q != 16'hFFFF)) begin
        overrun_cnt_q <= overrun_cnt_q + 16'd1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (tick_edge && enable_i && (num_servo_i != 5'd0)) begin
            n_q         <= num_servo_i;
            id_q        <= 5'd0;
            cmd_valid_q <= 1'b1;
            cmd_last_q  <= (num_servo_i == 5'd1);
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            cmd_last_q  <= 1'b0;
            to_cnt_q    <= '0;
            state_q     <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (done_i || to_expired) begin
            // done_i takes priority, so a coincident timeout is not counted.
            if (!done_i && (timeout_cnt_q != 16'hFFFF)) begin
              timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
            if (id_q == n_last) begin
              id_q         <= 5'd0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 16'd1;
              state_q      <= S_IDLE;
            end else begin
              id_q        <= id_d;
              cmd_valid_q <= 1'b1;
              cmd_last_q  <= (id_d == n_last);
              state_q     <= S_ISSUE;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_id_o      = id_q;
  assign cmd_last_o    = cmd_last_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign overrun_cnt_o = overrun_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: doc/interval_tick_sequencer.md
# interval_tick_sequencer

Consumer of the periodic interval-timer interrupt in the ICS servo interface. Each timer tick starts one polling frame that walks servo IDs 0..num_servo_i-1, issuing one command per ID to the ICS transaction engine over a valid/ready handshake and waiting for that transaction to complete. Ticks arriving while a frame is still in progress are dropped and counted as overruns. Stalled transactions are abandoned after a timeout and counted.

## Interface
- TIMEOUT, 100000, cycles allowed in WAIT_DONE before a transaction is abandoned (≥1)
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst  in  1  synchronous, active-high reset
- tick_i  in  1  interrupt from the interval timer; level, rising edge detected internally
- enable_i  in  1  when 0, ticks start no new frame and count no overrun
- num_servo_i  in  5  servos per frame, 0..31; sampled when a frame starts; 0 means ticks are ignored
- cmd_valid_o  out  1  command request to the ICS engine
- cmd_ready_i  in  1  ICS engine accepts the command
- cmd_id_o  out  5  servo ID of the current command
- cmd_last_o  out  1  current command is the last of the frame
- done_i  in  1  one-cycle pulse: ICS transaction complete
- busy_o  out  1  frame in progress (state ≠ IDLE)
- frame_done_o  out  1  one-cycle pulse at frame end
- frame_cnt_o  out  16  completed frames, wraps 0xFFFF→0
- overrun_cnt_o  out  16  dropped ticks, saturates at 0xFFFF
- timeout_cnt_o  out  16  abandoned transactions, saturates at 0xFFFF

## Operation
- Edge detect: tick_q <= tick_i; edge = tick_i & ~tick_q. tick_q resets to 0, so tick_i high in the first cycle after reset counts as an edge.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE: on edge with enable_i=1 and num_servo_i≠0:
  - latch n = num_servo_i;
  - id <= 0;
  - go to ISSUE.
- IDLE, other cases: an edge with enable_i=0 or num_servo_i=0 is ignored.
- ISSUE:
  - cmd_valid_o = 1; cmd_id_o = id; cmd_last_o = (id == n-1).
  - On cmd_valid_o & cmd_ready_i: go to WAIT_DONE and clear the timeout counter.
  - Once asserted, valid, id and last hold stable until accepted.
  - done_i is ignored in ISSUE.
- WAIT_DONE:
  - On done_i: if id == n-1, go to IDLE, pulse frame_done_o and increment frame_cnt_o. Otherwise id <= id+1 and go to ISSUE.
  - If the timeout counter reaches TIMEOUT-1 without done_i: increment timeout_cnt_o and take the same transition as done_i.
  - If done_i and the timeout occur in the same cycle, done_i wins and the timeout is not counted.
- Overrun: an edge while state ≠ IDLE and enable_i=1 increments overrun_cnt_o and starts no frame. This includes an edge in the same cycle as the frame-end transition.
- enable_i only gates frame starts. Deasserting it mid-frame does not abort the frame.
- A change to num_servo_i mid-frame has no effect on the frame in progress.

## Timing
- Reset values: state=IDLE, id=0, tick_q=0, all counters=0. All outputs read 0.
- Edge seen in cycle N → cmd_valid_o high from cycle N+1.
- Handshake in cycle M → cmd_valid_o low in M+1 (WAIT_DONE).
- done_i in cycle K:
  - not last ID: cmd_valid_o high at K+1 with the next ID;
  - last ID: busy_o low at K+1, frame_done_o high for cycle K+1 only, frame_cnt_o updated at K+1.
- Timeout: handshake in cycle M with no done_i → the timeout transition is taken at the edge ending cycle M+TIMEOUT.
- Minimum frame length for n servos with zero-wait ready and done the cycle after acceptance: 2n cycles.
- ap_rst mid-frame: the next cycle is IDLE with all outputs 0 and counters cleared. No frame_done_o pulse.
- Counter widths are fixed at 16 bits. frame_cnt_o uses modulo arithmetic; the other two counters saturate.

## Test plan
- Reset, num_servo_i=3, enable_i=1, ready tied 1, done_i one cycle after each acceptance, one tick → cmd_id_o sequence 0,1,2 with cmd_last_o only on ID 2; frame_done_o one pulse; frame_cnt_o=1; busy_o high for exactly 6 cycles.
- cmd_ready_i held low 5 cycles during ISSUE → cmd_valid_o and cmd_id_o stable for 6 cycles; accepted exactly once.
- Second tick edge mid-frame, plus a tick edge in the frame-end cycle → overrun_cnt_o=2; no extra frame; frame_cnt_o=1.
- TIMEOUT=16, done_i never asserted for ID 1 of 2 → timeout_cnt_o=1 at 16 cycles after ID 1's acceptance; the frame completes through the timeout path; frame_cnt_o=1.
- enable_i=0 tick → no activity, counters 0. num_servo_i=0 tick → ignored. num_servo_i=31 → IDs 0..30 issued, last on 30.
- ap_rst asserted while in WAIT_DONE → next cycle busy_o=0, cmd_valid_o=0, counters 0; a subsequent tick runs a normal frame from ID 0.
